// File: rtl/mydesign_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mydesign_pipe_pkg : shared sizing and legality helpers             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mydesign_pipe_pkg;

  localparam int MAX_PIPE = 8;

  function automatic int occ_w(input int n_pipe);
    return $clog2(n_pipe + 1);
  endfunction

  function automatic bit params_legal(input int n_pipe, input int reg_inputs);
    return (n_pipe >= 1) && (n_pipe <= MAX_PIPE) &&
           ((reg_inputs == 0) || ((reg_inputs == 1) && (n_pipe >= 2)));
  endfunction

  function automatic int stage0_w(input int reg_inputs, input int n_in, input int n_out);
    return (reg_inputs != 0) ? 2 * n_in : n_out;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mydesign_comb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mydesign_comb : combinational datapath, A*B reduced to N_OUT bits  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mydesign_comb #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 6
) (
  input  logic [N_IN-1:0]  operand_a_i,
  input  logic [N_IN-1:0]  operand_b_i,
  output logic [N_OUT-1:0] result_o
);

  logic [2*N_IN-1:0] w_prod;

  assign w_prod   = operand_a_i * operand_b_i;
  assign result_o = N_OUT'(w_prod);

endmodule
`default_nettype wire

// File: rtl/mydesign_pipe_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mydesign_pipe_stage : one valid+data pipeline register             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mydesign_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk_ci,
  input  logic         rst_ni,
  input  logic         load,
  input  logic         v_in,
  input  logic [W-1:0] d_in,
  output logic         v_q,
  output logic [W-1:0] d_q
);

  // Data only captures valid payloads so the output holds its last value across bubbles.
  always_ff @(posedge clk_ci or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else if (load) begin
      v_q <= v_in;
      if (v_in) begin
        d_q <= d_in;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mydesign_pipe_top.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mydesign_pipe_top : elastic valid/ready pipeline around comb core  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mydesign_pipe_top
  import mydesign_pipe_pkg::*;
#(
  parameter int N_IN       = 4,
  parameter int N_OUT      = 6,
  parameter int N_PIPE     = 2,
  parameter int REG_INPUTS = 1
) (
  input  logic                        clk_ci,
  input  logic                        rst_ni,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [N_IN-1:0]             operand_a_i,
  input  logic [N_IN-1:0]             operand_b_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [N_OUT-1:0]            result_o,
  output logic [occ_w(N_PIPE)-1:0]    occupancy_o
);

  localparam int OCC_W    = occ_w(N_PIPE);
  localparam int STAGE0_W = stage0_w(REG_INPUTS, N_IN, N_OUT);

  if (!params_legal(N_PIPE, REG_INPUTS)) begin : g_param_check
    $error("mydesign_pipe_top: illegal N_PIPE/REG_INPUTS combination");
  end

  logic [N_PIPE-1:0] w_v;
  logic [N_PIPE-1:0] w_adv;
  logic [N_OUT-1:0]  w_d [N_PIPE];
  logic [N_IN-1:0]   w_comb_a;
  logic [N_IN-1:0]   w_comb_b;
  logic [N_OUT-1:0]  w_comb_res;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic [OCC_W-1:0]  r_occ;

  // Ready chain: a stage may load if it is empty or its successor moves.
  always_comb begin
    w_adv = '0;
    w_adv[N_PIPE-1] = ~w_v[N_PIPE-1] | ready_i;
    for (int k = N_PIPE - 2; k >= 0; k--) begin
      w_adv[k] = ~w_v[k] | w_adv[k+1];
    end
  end

  (* dont_touch = "true" *)
  mydesign_comb #(
    .N_IN (N_IN),
    .N_OUT(N_OUT)
  ) u_comb (
    .operand_a_i(w_comb_a),
    .operand_b_i(w_comb_b),
    .result_o   (w_comb_res)
  );

  if (REG_INPUTS != 0) begin : g_reg_in
    logic [STAGE0_W-1:0] w_ops_q;

    mydesign_pipe_stage #(.W(STAGE0_W)) u_stage0 (
      .clk_ci(clk_ci),
      .rst_ni(rst_ni),
      .load  (w_adv[0]),
      .v_in  (valid_i),
      .d_in  ({operand_a_i, operand_b_i}),
      .v_q   (w_v[0]),
      .d_q   (w_ops_q)
    );

    assign w_comb_a = w_ops_q[2*N_IN-1:N_IN];
    assign w_comb_b = w_ops_q[N_IN-1:0];
    assign w_d[0]   = w_comb_res;
  end else begin : g_comb_in
    assign w_comb_a = operand_a_i;
    assign w_comb_b = operand_b_i;

    mydesign_pipe_stage #(.W(STAGE0_W)) u_stage0 (
      .clk_ci(clk_ci),
      .rst_ni(rst_ni),
      .load  (w_adv[0]),
      .v_in  (valid_i),
      .d_in  (w_comb_res),
      .v_q   (w_v[0]),
      .d_q   (w_d[0])
    );
  end

  for (genvar k = 1; k < N_PIPE; k++) begin : g_stage
    mydesign_pipe_stage #(.W(N_OUT)) u_stage (
      .clk_ci(clk_ci),
      .rst_ni(rst_ni),
      .load  (w_adv[k]),
      .v_in  (w_v[k-1]),
      .d_in  (w_d[k-1]),
      .v_q   (w_v[k]),
      .d_q   (w_d[k])
    );
  end

  assign ready_o    = w_adv[0];
  assign valid_o    = w_v[N_PIPE-1];
  assign result_o   = w_d[N_PIPE-1];
  assign w_in_xfer  = valid_i & ready_o;
  assign w_out_xfer = valid_o & ready_i;

  always_ff @(posedge clk_ci or negedge rst_ni) begin
    if (!rst_ni) begin
      r_occ <= '0;
    end else if (w_in_xfer && !w_out_xfer) begin
      r_occ <= r_occ + OCC_W'(1);
    end else if (!w_in_xfer && w_out_xfer) begin
      r_occ <= r_occ - OCC_W'(1);
    end
  end

  assign occupancy_o = r_occ;

  a_occ_matches_valids : assert property (
    @(posedge clk_ci) disable iff (!rst_ni) r_occ == OCC_W'($countones(w_v))
  );

endmodule
`default_nettype wire

// File: tb/tb_mydesign_pipe_top.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mydesign_pipe_top : scoreboard bench over three configurations  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mydesign_pipe_top;

  localparam int N_IN  = 4;
  localparam int N_OUT = 6;
  localparam int ND    = 3;

  logic            clk_ci = 1'b0;
  logic            rst_ni = 1'b0;
  logic            valid_i = 1'b0;
  logic            ready_i = 1'b1;
  logic [N_IN-1:0] operand_a_i = '0;
  logic [N_IN-1:0] operand_b_i = '0;
  logic            rdy_o [ND];
  logic            vld_o [ND];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit lat_mode = 1'b0;

  always #5 clk_ci = ~clk_ci;
  always @(posedge clk_ci) cyc <= cyc + 1;

  task automatic check(input string nm, input int idx, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", nm, idx, act, exp, $time);
    end
  endtask

  // Reference: the product of the operands, reduced modulo 2**N_OUT.
  function automatic int model(input int a, input int b);
    return (a * b) % (1 << N_OUT);
  endfunction

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    localparam int NP = (gi == 0) ? 2 : (gi == 1) ? 1 : 4;
    localparam int RI = (gi == 1) ? 0 : 1;
    localparam int OW = $clog2(NP + 1);

    logic             rdy;
    logic             vld;
    logic [N_OUT-1:0] res;
    logic [OW-1:0]    occ;
    int               exp_q [$];
    int               t_q [$];

    mydesign_pipe_top #(
      .N_IN      (N_IN),
      .N_OUT     (N_OUT),
      .N_PIPE    (NP),
      .REG_INPUTS(RI)
    ) u_dut (
      .clk_ci     (clk_ci),
      .rst_ni     (rst_ni),
      .valid_i    (valid_i),
      .ready_o    (rdy),
      .operand_a_i(operand_a_i),
      .operand_b_i(operand_b_i),
      .valid_o    (vld),
      .ready_i    (ready_i),
      .result_o   (res),
      .occupancy_o(occ)
    );

    assign rdy_o[gi] = rdy;
    assign vld_o[gi] = vld;

    always @(negedge clk_ci) begin
      if (!rst_ni) begin
        check("reset_valid_o", gi, int'(vld), 0);
        check("reset_occupancy", gi, int'(occ), 0);
        check("reset_result_o", gi, int'(res), 0);
        exp_q.delete();
        t_q.delete();
      end else begin
        check("occupancy", gi, int'(occ), exp_q.size());
        check("ready_o", gi, int'(rdy), int'((exp_q.size() < NP) || ready_i));
        if (vld && ready_i) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL output_without_input dut%0d: got result %0d expected no output (t=%0t)",
                     gi, res, $time);
          end else begin
            int e, t0;
            e  = exp_q.pop_front();
            t0 = t_q.pop_front();
            check("result_o", gi, int'(res), e);
            if (lat_mode) check("latency", gi, cyc - t0, NP);
          end
        end
        if (valid_i && rdy) begin
          exp_q.push_back(model(int'(operand_a_i), int'(operand_b_i)));
          t_q.push_back(cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_ci);
    #1;
  endtask

  initial begin
    int acc;
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();
    for (int i = 0; i < ND; i++) check("ready_after_reset", i, int'(rdy_o[i]), 1);
    repeat (2) tick();
    for (int i = 0; i < ND; i++) check("idle_valid_o", i, int'(vld_o[i]), 0);

    // Isolated transfer: 3*5 with latency measured per configuration.
    lat_mode    = 1'b1;
    operand_a_i = 4'd3;
    operand_b_i = 4'd5;
    valid_i     = 1'b1;
    tick();
    valid_i = 1'b0;
    repeat (8) tick();
    lat_mode = 1'b0;

    // Back-to-back stream.
    for (int i = 0; i < 16; i++) begin
      valid_i     = 1'b1;
      operand_a_i = 4'($urandom);
      operand_b_i = 4'($urandom);
      if (i >= 2) check("stream_occupancy", 0, int'(g_dut[0].occ), 2);
      tick();
    end
    valid_i = 1'b0;
    repeat (8) tick();

    // Downstream stall for four cycles.
    acc     = 0;
    ready_i = 1'b0;
    valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (rdy_o[0]) acc++;
      operand_a_i = 4'($urandom);
      operand_b_i = 4'($urandom);
      tick();
    end
    check("stall_accepts", 0, acc, 2);
    check("stall_ready_o", 0, int'(rdy_o[0]), 0);
    check("stall_occupancy", 0, int'(g_dut[0].occ), 2);
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (8) tick();

    // Reset with two transactions in flight.
    valid_i = 1'b1;
    repeat (2) begin
      operand_a_i = 4'($urandom);
      operand_b_i = 4'($urandom);
      tick();
    end
    valid_i = 1'b0;
    rst_ni  = 1'b0;
    #1;
    check("midreset_valid_o", 0, int'(vld_o[0]), 0);
    check("midreset_occupancy", 0, int'(g_dut[0].occ), 0);
    tick();
    tick();
    rst_ni = 1'b1;
    repeat (8) tick();

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      valid_i     = ($urandom_range(0, 1) == 1);
      ready_i     = ($urandom_range(0, 3) != 0);
      operand_a_i = 4'($urandom);
      operand_b_i = 4'($urandom);
      tick();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (20) tick();
    check("drained", 0, g_dut[0].exp_q.size(), 0);
    check("drained", 1, g_dut[1].exp_q.size(), 0);
    check("drained", 2, g_dut[2].exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
